// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter
// Description : Two-port (data=0, ifetch=1) arbiter in front of a single cache.
//               Build macro CACHE_ARB_RR_EN selects round-robin tie-breaking;
//               when undefined, port 0 wins every tie.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_arbiter #(
  parameter int d_width = 8,
  parameter int a_width = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               req0,
  input  logic               rw0,
  input  logic [a_width-1:0] addr0,
  input  logic [d_width-1:0] wdata0,
  output logic [d_width-1:0] rdata0,
  output logic               done0,
  input  logic               req1,
  input  logic               rw1,
  input  logic [a_width-1:0] addr1,
  input  logic [d_width-1:0] wdata1,
  output logic [d_width-1:0] rdata1,
  output logic               done1,
  output logic               busy,
  output logic [a_width-1:0] cache_addr,
  inout  wire  [d_width-1:0] cache_data,
  output logic               cache_rw,
  output logic               cache_ce,
  input  logic               cache_odv
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_port;
  logic               r_rw;
  logic [a_width-1:0] r_addr;
  logic [d_width-1:0] r_wdata;
  logic [d_width-1:0] r_rdata0;
  logic [d_width-1:0] r_rdata1;
  logic               r_done0;
  logic               r_done1;
  logic               w_pick1;
  logic               w_req_any;
  logic               w_drive;

  assign w_req_any = req0 | req1;

`ifdef CACHE_ARB_RR_EN
  logic r_last_grant;
  // On a tie, the port that did not win last time goes first.
  assign w_pick1 = req1 & (~req0 | ~r_last_grant);
`else
  assign w_pick1 = req1 & ~req0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_req_any) w_state_nxt = S_ISSUE;
      S_ISSUE:   w_state_nxt = S_WAIT;
      S_WAIT:    if (cache_odv) w_state_nxt = S_RECOVER;
      S_RECOVER: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= S_IDLE;
      r_port   <= 1'b0;
      r_rw     <= 1'b1;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
`ifdef CACHE_ARB_RR_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      if (r_state == S_IDLE && w_req_any) begin
        r_port  <= w_pick1;
        r_rw    <= w_pick1 ? rw1    : rw0;
        r_addr  <= w_pick1 ? addr1  : addr0;
        r_wdata <= w_pick1 ? wdata1 : wdata0;
`ifdef CACHE_ARB_RR_EN
        r_last_grant <= w_pick1;
`endif
      end
      // done and read data are registered so they appear together in RECOVER.
      if (r_state == S_WAIT && cache_odv) begin
        if (r_port) r_done1 <= 1'b1;
        else        r_done0 <= 1'b1;
        if (r_rw && r_port)  r_rdata1 <= cache_data;
        if (r_rw && !r_port) r_rdata0 <= cache_data;
      end
    end
  end

  assign cache_ce   = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign cache_rw   = cache_ce ? r_rw : 1'b1;
  assign cache_addr = r_addr;
  assign w_drive    = cache_ce && !r_rw;
  assign cache_data = w_drive ? r_wdata : {d_width{1'bz}};

  assign busy   = (r_state != S_IDLE);
  assign done0  = r_done0;
  assign done1  = r_done1;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_arbiter
// Description : Scoreboard bench for cache_arbiter with a behavioural cache.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       req0 = 1'b0, rw0 = 1'b1, req1 = 1'b0, rw1 = 1'b1;
  logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  wire  [7:0] rdata0, rdata1, cache_addr;
  wire        done0, done1, busy, cache_rw, cache_ce;
  wire  [7:0] cache_data;
  logic       cache_odv;

  cache_arbiter #(.d_width(8), .a_width(8)) dut (
    .clk(clk), .clr(clr),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .done0(done0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .done1(done1),
    .busy(busy), .cache_addr(cache_addr), .cache_data(cache_data),
    .cache_rw(cache_rw), .cache_ce(cache_ce), .cache_odv(cache_odv)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural cache: hit answers one edge after ce, miss answers on the 8th edge.
  logic [7:0] mem [256];
  logic       vld [256];
  logic [7:0] m_out;
  logic [3:0] m_tmr;

  function automatic logic [7:0] ram_val(input logic [7:0] a);
    return a ^ 8'hB7;
  endfunction

  assign cache_data = (cache_ce && cache_rw && cache_odv) ? m_out : 8'hzz;

  always @(posedge clk) begin
    if (clr || !cache_ce) begin
      cache_odv <= 1'b0;
      m_tmr     <= '0;
    end else if (vld[cache_addr] || m_tmr == 4'd7) begin
      cache_odv       <= 1'b1;
      vld[cache_addr] <= 1'b1;
      if (cache_rw) begin
        m_out <= vld[cache_addr] ? mem[cache_addr] : ram_val(cache_addr);
        if (!vld[cache_addr]) mem[cache_addr] <= ram_val(cache_addr);
      end else begin
        mem[cache_addr] <= cache_data;
      end
    end else begin
      m_tmr <= m_tmr + 4'd1;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         port;
    int         cyc;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sbq[$];
  int         n_done = 0;
  logic [7:0] last_rd[2] = '{8'h00, 8'h00};

  always @(negedge clk) begin
    if (done0 || done1) begin
      exp_t e;
      n_done++;
      check_eq("done_exclusive", 32'(done0 & done1), 32'd0);
      if (sbq.size() == 0) begin
        check_eq("done_unexpected", 32'(sbq.size()), 32'd1);
      end else begin
        e = sbq.pop_front();
        check_eq("done_port", done1 ? 32'd1 : 32'd0, 32'(e.port));
        check_eq("done_cycle", 32'(cyc), 32'(e.cyc));
        check_eq("rdata", 32'(e.port != 0 ? rdata1 : rdata0), 32'(e.rdata));
      end
    end
  end

  // Drive one request in the current cycle (cycle 0) and queue its expected completion.
  task automatic issue(input int port, input logic rw, input logic [7:0] a,
                       input logic [7:0] wd, input bit hit, input logic [7:0] exp_rd);
    exp_t e;
    if (port != 0) begin req1 = 1'b1; rw1 = rw; addr1 = a; wdata1 = wd; end
    else           begin req0 = 1'b1; rw0 = rw; addr0 = a; wdata0 = wd; end
    e.port  = port;
    e.cyc   = cyc + (hit ? 3 : 10);
    if (rw) last_rd[port] = exp_rd;
    e.rdata = last_rd[port];
    sbq.push_back(e);
  endtask

  task automatic at_cyc(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && n_done < target; i++) @(posedge clk);
    if (n_done < target) check_eq("done_timeout", 32'(n_done), 32'(target));
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    for (int i = 0; i < 256; i++) begin vld[i] = 1'b0; mem[i] = '0; end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ce", 32'(cache_ce), 32'd0);
    check_eq("rst_rw", 32'(cache_rw), 32'd1);
    check_eq("rst_addr", 32'(cache_addr), 32'd0);
    check_eq("rst_done", {30'd0, done1, done0}, 32'd0);
    check_eq("rst_rdata", {16'd0, rdata1, rdata0}, 32'd0);
    @(posedge clk); #1 clr = 1'b0;

    // Read miss of 0x12 with the address changed mid-WAIT
    @(posedge clk); #1;
    t0 = cyc;
    issue(0, 1'b1, 8'h12, 8'h77, 1'b0, 8'hA5);
    at_cyc(t0 + 1);
    check_eq("issue_ce", 32'(cache_ce), 32'd1);
    check_eq("issue_rw_read", 32'(cache_rw), 32'd1);
    check_eq("read_bus_not_driven", 32'(cache_data === 8'h77), 32'd0);
    check_eq("issue_busy", 32'(busy), 32'd1);
    at_cyc(t0 + 4);
    addr0 = 8'h55;
    at_cyc(t0 + 6);
    check_eq("held_addr_mid", 32'(cache_addr), 32'h12);
    at_cyc(t0 + 9);
    check_eq("held_addr_end", 32'(cache_addr), 32'h12);
    check_eq("wait_ce", 32'(cache_ce), 32'd1);
    at_cyc(t0 + 10);
    check_eq("recover_ce", 32'(cache_ce), 32'd0);
    check_eq("recover_rw", 32'(cache_rw), 32'd1);
    wait_done(1, 20);
    req0 = 1'b0;

    // Read hit of 0x12
    t0 = cyc;
    issue(0, 1'b1, 8'h12, 8'h00, 1'b1, 8'hA5);
    at_cyc(t0 + 1);
    check_eq("hit_ce_c1", 32'(cache_ce), 32'd1);
    at_cyc(t0 + 2);
    check_eq("hit_ce_c2", 32'(cache_ce), 32'd1);
    wait_done(2, 20);
    req0 = 1'b0;

    // Write miss on port 1, then read it back as a hit
    t0 = cyc;
    issue(1, 1'b0, 8'h40, 8'h3C, 1'b0, 8'h00);
    at_cyc(t0 + 1);
    check_eq("wr_bus_issue", 32'(cache_data), 32'h3C);
    check_eq("wr_rw", 32'(cache_rw), 32'd0);
    at_cyc(t0 + 5);
    check_eq("wr_bus_wait", 32'(cache_data), 32'h3C);
    at_cyc(t0 + 10);
    check_eq("wr_bus_released", 32'(cache_data === 8'h3C), 32'd0);
    wait_done(3, 20);
    req1 = 1'b0;
    t0 = cyc;
    issue(1, 1'b1, 8'h40, 8'h00, 1'b1, 8'h3C);
    wait_done(4, 20);
    req1 = 1'b0;

    // Tie: both ports held for four transactions, all hits
    t0 = cyc;
    req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h12;
    req1 = 1'b1; rw1 = 1'b1; addr1 = 8'h40;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
`ifdef CACHE_ARB_RR_EN
      e.port = k % 2;
`else
      e.port = 0;
`endif
      e.cyc   = t0 + 3 + 4 * k;
      e.rdata = (e.port != 0) ? 8'h3C : 8'hA5;
      sbq.push_back(e);
    end
    wait_done(8, 40);
    req0 = 1'b0; req1 = 1'b0;

    // Reset in the middle of a miss
    t0 = cyc;
    req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h90;
    at_cyc(t0 + 4);
    @(posedge clk); #1;
    clr = 1'b1; req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_ce", 32'(cache_ce), 32'd0);
    check_eq("midrst_done", {30'd0, done1, done0}, 32'd0);
    check_eq("midrst_rdata0", 32'(rdata0), 32'd0);
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    @(posedge clk); #1 clr = 1'b0;
    @(posedge clk); #1;
    t0 = cyc;
    issue(0, 1'b1, 8'h90, 8'h00, 1'b0, 8'h27);
    wait_done(9, 30);
    req0 = 1'b0;

    repeat (3) @(posedge clk);
    check_eq("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
